// File: rtl/timestamp_gen.sv
// timestamp_gen: mission-elapsed-time counter with prescaler, preload,
// wrap/saturate at full scale, rollover pulse + sticky flag, and a
// snapshot register with valid/ack handshake and drop indication.
module timestamp_gen #(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned PRESCALE  = 1,
  parameter bit          WRAP_MODE = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             TICK_EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VALUE,
  input  logic             SNAP_REQ,
  input  logic             SNAP_ACK,
  output logic [WIDTH-1:0] TIMESTAMP,
  output logic             ROLLOVER,
  output logic             OVF_STICKY,
  output logic [WIDTH-1:0] SNAP_VALUE,
  output logic             SNAP_VALID,
  output logic             SNAP_DROP
);

  // Prescaler width: ceil(log2(PRESCALE)), never below one bit.
  localparam int unsigned      PRE_W    = (PRESCALE > 32'd2) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 32'd1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [PRE_W-1:0] pre_cnt_r;
  logic [PRE_W-1:0] pre_cnt_nxt_s;
  logic             step_s;
  logic [WIDTH-1:0] ts_nxt_s;
  logic             roll_nxt_s;
  logic             sticky_nxt_s;
  logic [WIDTH-1:0] snap_val_nxt_s;
  logic             snap_valid_nxt_s;
  logic             snap_drop_nxt_s;

  // Prescaler and timestamp next-state: LOAD wins over STEP, STEP over hold.
  always_comb begin
    step_s        = 1'b0;
    pre_cnt_nxt_s = pre_cnt_r;
    ts_nxt_s      = TIMESTAMP;
    roll_nxt_s    = 1'b0;
    sticky_nxt_s  = OVF_STICKY;

    if (TICK_EN) begin
      if (pre_cnt_r == PRE_LAST) begin
        pre_cnt_nxt_s = '0;
        step_s        = 1'b1;
      end else begin
        pre_cnt_nxt_s = pre_cnt_r + PRE_W'(1);
      end
    end else begin
      pre_cnt_nxt_s = pre_cnt_r;
    end

    if (LOAD) begin
      // A coincident step is discarded; the prescaler restarts its period.
      pre_cnt_nxt_s = '0;
      ts_nxt_s      = LOAD_VALUE;
      sticky_nxt_s  = 1'b0;
      roll_nxt_s    = 1'b0;
    end else if (step_s) begin
      if (TIMESTAMP != ALL_ONES) begin
        ts_nxt_s = TIMESTAMP + WIDTH'(1);
      end else begin
        sticky_nxt_s = 1'b1;
        if (WRAP_MODE) begin
          ts_nxt_s   = '0;
          roll_nxt_s = 1'b1;
        end else begin
          // Saturated: report the overflow only the first time.
          ts_nxt_s   = ALL_ONES;
          roll_nxt_s = ~OVF_STICKY;
        end
      end
    end else begin
      ts_nxt_s = TIMESTAMP;
    end
  end

  // Snapshot handshake next-state; captures the pre-update timestamp.
  always_comb begin
    snap_val_nxt_s   = SNAP_VALUE;
    snap_valid_nxt_s = SNAP_VALID;
    snap_drop_nxt_s  = 1'b0;
    if (SNAP_REQ && (!SNAP_VALID || SNAP_ACK)) begin
      snap_val_nxt_s   = TIMESTAMP;
      snap_valid_nxt_s = 1'b1;
    end else if (SNAP_REQ) begin
      // Unacknowledged capture still pending: refuse and flag it.
      snap_drop_nxt_s = 1'b1;
    end else if (SNAP_ACK) begin
      snap_valid_nxt_s = 1'b0;
    end else begin
      snap_valid_nxt_s = SNAP_VALID;
    end
  end

  // State and output registers; reset clears everything including the prescaler.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pre_cnt_r  <= '0;
      TIMESTAMP  <= '0;
      ROLLOVER   <= 1'b0;
      OVF_STICKY <= 1'b0;
      SNAP_VALUE <= '0;
      SNAP_VALID <= 1'b0;
      SNAP_DROP  <= 1'b0;
    end else begin
      pre_cnt_r  <= pre_cnt_nxt_s;
      TIMESTAMP  <= ts_nxt_s;
      ROLLOVER   <= roll_nxt_s;
      OVF_STICKY <= sticky_nxt_s;
      SNAP_VALUE <= snap_val_nxt_s;
      SNAP_VALID <= snap_valid_nxt_s;
      SNAP_DROP  <= snap_drop_nxt_s;
    end
  end

endmodule

// File: tb/tb_timestamp_gen.sv
// tb_timestamp_gen: drives a wrapping and a saturating instance (WIDTH=8,
// PRESCALE=3) with shared inputs and compares both against an arithmetic
// model: timestamp = base + (enabled cycles since load)/3.
module tb_timestamp_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_en, load, snap_req, snap_ack;
  logic [7:0] load_value;

  logic [7:0] ts_w, sv_w, ts_s, sv_s;
  logic       roll_w, sticky_w, valid_w, drop_w;
  logic       roll_s, sticky_s, valid_s, drop_s;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         base, en_cnt;
  bit         m_step, m_valid, m_drop;
  logic [7:0] m_sv_w, m_sv_s;

  timestamp_gen #(.WIDTH(8), .PRESCALE(3), .WRAP_MODE(1'b1)) dut_w (
    .CLK(clk), .RESET_N(rst_n), .TICK_EN(tick_en), .LOAD(load), .LOAD_VALUE(load_value),
    .SNAP_REQ(snap_req), .SNAP_ACK(snap_ack), .TIMESTAMP(ts_w), .ROLLOVER(roll_w),
    .OVF_STICKY(sticky_w), .SNAP_VALUE(sv_w), .SNAP_VALID(valid_w), .SNAP_DROP(drop_w));

  timestamp_gen #(.WIDTH(8), .PRESCALE(3), .WRAP_MODE(1'b0)) dut_s (
    .CLK(clk), .RESET_N(rst_n), .TICK_EN(tick_en), .LOAD(load), .LOAD_VALUE(load_value),
    .SNAP_REQ(snap_req), .SNAP_ACK(snap_ack), .TIMESTAMP(ts_s), .ROLLOVER(roll_s),
    .OVF_STICKY(sticky_s), .SNAP_VALUE(sv_s), .SNAP_VALID(valid_s), .SNAP_DROP(drop_s));

  always #5 clk = ~clk;

  function automatic int f_t();
    return base + en_cnt / 3;
  endfunction

  function automatic logic [7:0] f_ts(input bit wrap);
    int t;
    t = f_t();
    if (wrap) return 8'(t % 256);
    return (t > 255) ? 8'hFF : 8'(t);
  endfunction

  function automatic logic f_roll(input bit wrap);
    if (!m_step) return 1'b0;
    if (wrap) return (f_t() % 256) == 0;
    return f_t() == 256;
  endfunction

  function automatic logic [19:0] exp_vec(input bit wrap);
    return {f_ts(wrap), f_roll(wrap), 1'(f_t() > 255), wrap ? m_sv_w : m_sv_s, 1'(m_valid), 1'(m_drop)};
  endfunction

  task automatic model_reset();
    base = 0; en_cnt = 0; m_step = 0; m_valid = 0; m_drop = 0;
    m_sv_w = 8'h00; m_sv_s = 8'h00;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then settle.
  task automatic clk_cycle();
    logic [7:0] pw, ps;
    @(posedge clk);
    pw = f_ts(1'b1);
    ps = f_ts(1'b0);
    if (snap_req && (!m_valid || snap_ack)) begin
      m_sv_w = pw; m_sv_s = ps; m_valid = 1; m_drop = 0;
    end else if (snap_req) begin
      m_drop = 1;
    end else begin
      m_drop = 0;
      if (snap_ack) m_valid = 0;
    end
    m_step = 0;
    if (load) begin
      base = int'(load_value); en_cnt = 0;
    end else if (tick_en) begin
      en_cnt++;
      m_step = (en_cnt % 3) == 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick_en = 1'b0; load = 1'b0; load_value = 8'h00;
    snap_req = 1'b0; snap_ack = 1'b0;
    model_reset();
    #12;
    total++;
    if ({ts_w, roll_w, sticky_w, sv_w, valid_w, drop_w} !== 20'h0) begin
      bad++; $display("FAIL reset_w: got %h want %h", {ts_w, roll_w, sticky_w, sv_w, valid_w, drop_w}, 20'h0);
    end
    total++;
    if ({ts_s, roll_s, sticky_s, sv_s, valid_s, drop_s} !== 20'h0) begin
      bad++; $display("FAIL reset_s: got %h want %h", {ts_s, roll_s, sticky_s, sv_s, valid_s, drop_s}, 20'h0);
    end
  endtask

  task automatic test_count();
    @(negedge clk);
    rst_n = 1'b1; tick_en = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      clk_cycle();
      total++;
      if (ts_w !== 8'(i / 3) || roll_w !== 1'b0) begin
        bad++; $display("FAIL count[%0d]: got ts=%h roll=%b want ts=%h roll=0", i, ts_w, roll_w, 8'(i / 3));
      end
      total++;
      if ({ts_s, roll_s, sticky_s, sv_s, valid_s, drop_s} !== exp_vec(1'b0)) begin
        bad++; $display("FAIL count_s[%0d]: got %h want %h", i, {ts_s, roll_s, sticky_s, sv_s, valid_s, drop_s}, exp_vec(1'b0));
      end
    end
  endtask

  task automatic test_load_wrap();
    int rolls;
    load = 1'b1; load_value = 8'hFE;
    clk_cycle();
    load = 1'b0;
    total++;
    if (ts_w !== 8'hFE || sticky_w !== 1'b0) begin
      bad++; $display("FAIL load_fe: got ts=%h sticky=%b want ts=fe sticky=0", ts_w, sticky_w);
    end
    rolls = 0;
    for (int i = 1; i <= 6; i++) begin
      clk_cycle();
      rolls += int'(roll_w);
      total++;
      if ({ts_w, roll_w, sticky_w, sv_w, valid_w, drop_w} !== exp_vec(1'b1)) begin
        bad++; $display("FAIL wrap[%0d]: got %h want %h", i, {ts_w, roll_w, sticky_w, sv_w, valid_w, drop_w}, exp_vec(1'b1));
      end
      total++;
      if ({ts_s, roll_s, sticky_s, sv_s, valid_s, drop_s} !== exp_vec(1'b0)) begin
        bad++; $display("FAIL wrap_s[%0d]: got %h want %h", i, {ts_s, roll_s, sticky_s, sv_s, valid_s, drop_s}, exp_vec(1'b0));
      end
    end
    total++;
    if (rolls !== 1 || ts_w !== 8'h00 || sticky_w !== 1'b1) begin
      bad++; $display("FAIL wrap_end: got rolls=%0d ts=%h sticky=%b want rolls=1 ts=00 sticky=1", rolls, ts_w, sticky_w);
    end
    load = 1'b1; load_value = 8'h10;
    clk_cycle();
    load = 1'b0;
    total++;
    if (ts_w !== 8'h10 || sticky_w !== 1'b0 || sticky_s !== 1'b0) begin
      bad++; $display("FAIL load_clear: got ts=%h sticky=%b/%b want ts=10 sticky=0/0", ts_w, sticky_w, sticky_s);
    end
  endtask

  task automatic test_sat();
    int rolls;
    load = 1'b1; load_value = 8'hFF;
    clk_cycle();
    load = 1'b0;
    rolls = 0;
    for (int i = 1; i <= 9; i++) begin
      clk_cycle();
      rolls += int'(roll_s);
      total++;
      if (ts_s !== 8'hFF || roll_s !== 1'(i == 3)) begin
        bad++; $display("FAIL sat[%0d]: got ts=%h roll=%b want ts=ff roll=%b", i, ts_s, roll_s, 1'(i == 3));
      end
      total++;
      if ({ts_w, roll_w, sticky_w, sv_w, valid_w, drop_w} !== exp_vec(1'b1)) begin
        bad++; $display("FAIL sat_w[%0d]: got %h want %h", i, {ts_w, roll_w, sticky_w, sv_w, valid_w, drop_w}, exp_vec(1'b1));
      end
    end
    total++;
    if (rolls !== 1 || sticky_s !== 1'b1) begin
      bad++; $display("FAIL sat_end: got rolls=%0d sticky=%b want rolls=1 sticky=1", rolls, sticky_s);
    end
  endtask

  task automatic test_tick_en();
    logic [4:0] pat;
    pat = 5'b11001;
    load = 1'b1; load_value = 8'h00;
    clk_cycle();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick_en = pat[i];
      clk_cycle();
      total++;
      if (ts_w !== 8'(i == 4) || ts_w !== f_ts(1'b1)) begin
        bad++; $display("FAIL tick_en[%0d]: got ts=%h want ts=%h", i, ts_w, 8'(i == 4));
      end
    end
  endtask

  task automatic test_snapshot();
    tick_en = 1'b0;
    load = 1'b1; load_value = 8'h42;
    clk_cycle();
    load = 1'b0; snap_req = 1'b1;
    clk_cycle();
    total++;
    if (sv_w !== 8'h42 || valid_w !== 1'b1 || drop_w !== 1'b0) begin
      bad++; $display("FAIL snap_cap: got sv=%h v=%b d=%b want sv=42 v=1 d=0", sv_w, valid_w, drop_w);
    end
    clk_cycle();
    total++;
    if (sv_w !== 8'h42 || valid_w !== 1'b1 || drop_w !== 1'b1) begin
      bad++; $display("FAIL snap_drop: got sv=%h v=%b d=%b want sv=42 v=1 d=1", sv_w, valid_w, drop_w);
    end
    snap_req = 1'b0; load = 1'b1; load_value = 8'h45;
    clk_cycle();
    total++;
    if (drop_w !== 1'b0 || valid_w !== 1'b1) begin
      bad++; $display("FAIL snap_drop_pulse: got d=%b v=%b want d=0 v=1", drop_w, valid_w);
    end
    load = 1'b0; snap_req = 1'b1; snap_ack = 1'b1;
    clk_cycle();
    total++;
    if (sv_w !== 8'h45 || valid_w !== 1'b1 || drop_w !== 1'b0) begin
      bad++; $display("FAIL snap_b2b: got sv=%h v=%b d=%b want sv=45 v=1 d=0", sv_w, valid_w, drop_w);
    end
    snap_req = 1'b0;
    clk_cycle();
    total++;
    if (valid_w !== 1'b0 || sv_w !== 8'h45) begin
      bad++; $display("FAIL snap_ack: got v=%b sv=%h want v=0 sv=45", valid_w, sv_w);
    end
    snap_ack = 1'b0; snap_req = 1'b1; load = 1'b1; load_value = 8'h77;
    clk_cycle();
    total++;
    if (sv_w !== 8'h45 || ts_w !== 8'h77 || valid_w !== 1'b1) begin
      bad++; $display("FAIL snap_preload: got sv=%h ts=%h v=%b want sv=45 ts=77 v=1", sv_w, ts_w, valid_w);
    end
    snap_req = 1'b0; load = 1'b0; snap_ack = 1'b1;
    clk_cycle();
    snap_ack = 1'b0;
    total++;
    if ({ts_s, roll_s, sticky_s, sv_s, valid_s, drop_s} !== exp_vec(1'b0)) begin
      bad++; $display("FAIL snap_s: got %h want %h", {ts_s, roll_s, sticky_s, sv_s, valid_s, drop_s}, exp_vec(1'b0));
    end
  endtask

  task automatic test_reset_mid();
    tick_en = 1'b1; load = 1'b1; load_value = 8'h33;
    clk_cycle();
    load = 1'b0; snap_req = 1'b1;
    clk_cycle();
    snap_req = 1'b0;
    clk_cycle();
    total++;
    if (valid_w !== 1'b1 || ts_w !== 8'h33) begin
      bad++; $display("FAIL mid_pre: got v=%b ts=%h want v=1 ts=33", valid_w, ts_w);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if ({ts_w, roll_w, sticky_w, sv_w, valid_w, drop_w, ts_s, roll_s, sticky_s, sv_s, valid_s, drop_s} !== 40'h0) begin
      bad++; $display("FAIL mid_async: got %h want 0", {ts_w, roll_w, sticky_w, sv_w, valid_w, drop_w, ts_s, roll_s, sticky_s, sv_s, valid_s, drop_s});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk_cycle();
      total++;
      if (ts_w !== 8'(i == 2) || valid_w !== 1'b0) begin
        bad++; $display("FAIL mid_restart[%0d]: got ts=%h v=%b want ts=%h v=0", i, ts_w, valid_w, 8'(i == 2));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      tick_en  = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 24) == 0);
      load_value = ($urandom_range(0, 1) == 1) ? 8'(8'hF0 + $urandom_range(0, 15)) : 8'($urandom);
      snap_req = ($urandom_range(0, 2) == 0);
      snap_ack = ($urandom_range(0, 2) == 0);
      clk_cycle();
      total++;
      if ({ts_w, roll_w, sticky_w, sv_w, valid_w, drop_w} !== exp_vec(1'b1)) begin
        bad++; $display("FAIL rand_w[%0d]: got %h want %h", i, {ts_w, roll_w, sticky_w, sv_w, valid_w, drop_w}, exp_vec(1'b1));
      end
      total++;
      if ({ts_s, roll_s, sticky_s, sv_s, valid_s, drop_s} !== exp_vec(1'b0)) begin
        bad++; $display("FAIL rand_s[%0d]: got %h want %h", i, {ts_s, roll_s, sticky_s, sv_s, valid_s, drop_s}, exp_vec(1'b0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_load_wrap();
    test_sat();
    test_tick_en();
    test_snapshot();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timestamp_gen.md
Name: timestamp_gen

Overview:
- Parametrised mission-elapsed-time counter, successor to the fixed 24-bit 10 Hz tick counter.
- Runs from one system clock. A built-in prescaler and an external enable set the tick rate.
- Adds preload, a choice of wrap or saturate at full scale, a rollover pulse with a sticky flag, and a snapshot register with a valid/ack handshake.
- Feeds the telemetry packetiser and the housekeeping logger with coherent timestamps.

Parameters:
- WIDTH, 24: timestamp width in bits (2..48).
- PRESCALE, 1: qualified clock cycles per timestamp step (1..2^16). Value 1 means step on every enabled cycle.
- WRAP_MODE, 1: 1 = wrap to 0 after all-ones; 0 = saturate at all-ones.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- TICK_EN  in  1  qualifies the prescaler; while low, the prescaler and timestamp hold.
- LOAD  in  1  synchronous preload strobe.
- LOAD_VALUE  in  WIDTH  preload value.
- SNAP_REQ  in  1  snapshot request, sampled each cycle.
- SNAP_ACK  in  1  consumer acknowledge of the snapshot.
- TIMESTAMP  out  WIDTH  running count (registered).
- ROLLOVER  out  1  one-cycle pulse when a step occurs at full scale.
- OVF_STICKY  out  1  set by any rollover; cleared only by LOAD or reset.
- SNAP_VALUE  out  WIDTH  captured timestamp.
- SNAP_VALID  out  1  SNAP_VALUE holds an unacknowledged capture.
- SNAP_DROP  out  1  one-cycle pulse when a request is refused.

Behaviour:
- Reset (asynchronous, RESET_N=0): all outputs are 0 and the prescaler count PRE_CNT is 0. Asserting reset mid-operation aborts any pending snapshot. Release is synchronous to the next CLK edge.
- Prescaler: PRE_CNT is ceil(log2(PRESCALE)) bits, minimum 1.
  - TICK_EN=1 and PRE_CNT<PRESCALE-1: PRE_CNT increments.
  - TICK_EN=1 and PRE_CNT=PRESCALE-1: PRE_CNT goes to 0 and STEP is asserted that cycle.
  - TICK_EN=0: PRE_CNT holds and no STEP.
- Priority per cycle: LOAD > STEP > hold.
  - LOAD=1: next TIMESTAMP=LOAD_VALUE, PRE_CNT=0, OVF_STICKY=0, ROLLOVER=0. Any coincident STEP is discarded.
  - STEP with TIMESTAMP<all-ones: TIMESTAMP+1. Latency is 1 clock from the qualifying edge.
  - STEP with TIMESTAMP=all-ones, WRAP_MODE=1: TIMESTAMP=0, ROLLOVER=1 for one cycle, OVF_STICKY=1.
  - STEP with TIMESTAMP=all-ones, WRAP_MODE=0: TIMESTAMP stays all-ones and OVF_STICKY=1. ROLLOVER pulses only if OVF_STICKY was 0 beforehand, so it pulses once per saturation.
- ROLLOVER is registered and aligned with the TIMESTAMP update it describes.
- Snapshot capture: SNAP_VALUE takes TIMESTAMP as registered in the request cycle (the pre-update value). SNAP_VALID rises on the next edge.
- Snapshot handshake:
  - SNAP_REQ=1, SNAP_VALID=0: capture occurs and SNAP_VALID becomes 1.
  - SNAP_ACK=1, SNAP_VALID=1, SNAP_REQ=0: SNAP_VALID becomes 0. SNAP_VALUE holds its last value.
  - SNAP_REQ=1, SNAP_VALID=1, SNAP_ACK=1: new capture occurs and SNAP_VALID stays 1 (back-to-back).
  - SNAP_REQ=1, SNAP_VALID=1, SNAP_ACK=0: request refused, SNAP_VALUE unchanged, SNAP_DROP=1 for one cycle.
  - SNAP_ACK while SNAP_VALID=0: ignored.
- Snapshot vs. counter: the snapshot path is independent of LOAD and STEP. A snapshot taken in a LOAD cycle returns the pre-load value.
- Arithmetic is unsigned, WIDTH bits, with no carry out except as described for ROLLOVER.

Test Plan:
- WIDTH=8, PRESCALE=3, WRAP_MODE=1, TICK_EN=1 from reset, 9 clocks → TIMESTAMP steps 0→1→2→3, one step every 3rd cycle. ROLLOVER=0.
- LOAD=1 with LOAD_VALUE=8'hFE, then 6 enabled clocks → TIMESTAMP FE→FF→00. ROLLOVER pulses exactly once with the 00 update, OVF_STICKY=1. A following LOAD with value 8'h10 clears the sticky and gives TIMESTAMP=10.
- WRAP_MODE=0, load 8'hFF, 9 enabled clocks → TIMESTAMP stays FF. ROLLOVER pulses once on the first step, OVF_STICKY=1.
- TICK_EN toggled 1,0,0,1,1 with PRESCALE=3 from PRE_CNT=0 → a single step occurs only on the 5th cycle. The prescaler holds while TICK_EN is low.
- SNAP_REQ at TIMESTAMP=8'h42 → SNAP_VALUE=42 and SNAP_VALID=1 next cycle.
  - Second SNAP_REQ without ACK → SNAP_DROP pulse, SNAP_VALUE stays 42.
  - REQ+ACK together at TIMESTAMP=45 → SNAP_VALUE=45, SNAP_VALID stays 1.
  - ACK alone → SNAP_VALID=0.
- Assert RESET_N=0 mid-count with SNAP_VALID=1 and PRE_CNT=2 → all outputs 0 asynchronously. After release, counting restarts from 0 with a full prescale period.
